// File: rtl/nib_pack.sv
// rtl/nib_pack.sv - nibble packer: assembles four framed 4-bit nibbles into one 16-bit word
// Valid/ready on both sides; SYNC_ERR pulses on a start-of-word inside a partial word.
module nib_pack #(
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       NIB_DATA,
  input  logic             NIB_VALID,
  input  logic             NIB_SOW,
  output logic             NIB_READY,
  output logic [15:0]      NIBBLES,
  output logic             WORD_VALID,
  input  logic             WORD_READY,
  output logic             SYNC_ERR,
  output logic [CNT_W-1:0] WORD_CNT
);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t           state, state_nx;
  logic [1:0]       idx, idx_nx;
  logic [11:0]      acc, acc_nx;
  logic [15:0]      word_q, word_nx;
  logic             wv_q, wv_nx;
  logic             err_q, err_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             accept;
  logic             deliver;

  // Accumulator holds nibbles 0..2 in their final word positions (minus the last slot).
  function automatic logic [11:0] place(input logic [11:0] a, input logic [1:0] k,
                                        input logic [3:0] d);
    logic [11:0] r;
    r = a;
    if (MSB_FIRST != 0) r[11 - 4*int'(k) -: 4] = d;
    else                r[4*int'(k) +: 4]      = d;
    return r;
  endfunction

  // Only the completing nibble stalls, and only while the previous word is still pending.
  assign NIB_READY = !(state == COLLECT && idx == 2'd3 && wv_q && !WORD_READY);
  assign accept    = NIB_VALID && NIB_READY;
  assign deliver   = wv_q && WORD_READY;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    acc_nx   = acc;
    word_nx  = word_q;
    wv_nx    = wv_q;
    err_nx   = 1'b0;
    cnt_nx   = cnt_q;

    if (deliver) begin
      wv_nx  = 1'b0;
      cnt_nx = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    if (accept) begin
      if (NIB_SOW) begin
        err_nx   = (state == COLLECT);
        acc_nx   = place(12'h000, 2'd0, NIB_DATA);
        idx_nx   = 2'd1;
        state_nx = COLLECT;
      end else if (state == COLLECT) begin
        if (idx == 2'd3) begin
          word_nx  = (MSB_FIRST != 0) ? {acc, NIB_DATA} : {NIB_DATA, acc};
          wv_nx    = 1'b1;
          idx_nx   = 2'd0;
          state_nx = HUNT;
        end else begin
          acc_nx = place(acc, idx, NIB_DATA);
          idx_nx = idx + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= HUNT;
      idx    <= 2'd0;
      acc    <= 12'h000;
      word_q <= 16'h0000;
      wv_q   <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      acc    <= acc_nx;
      word_q <= word_nx;
      wv_q   <= wv_nx;
      err_q  <= err_nx;
      cnt_q  <= cnt_nx;
    end
  end

  assign NIBBLES    = word_q;
  assign WORD_VALID = wv_q;
  assign SYNC_ERR   = err_q;
  assign WORD_CNT   = cnt_q;

endmodule

// File: tb/tb_nib_pack.sv
// tb/tb_nib_pack.sv - directed self-checking bench for nib_pack
// Two instances share stimulus: default MSB-first and an LSB-first build.
module tb_nib_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  nib_data = 4'h0;
  logic        nib_valid = 1'b0;
  logic        nib_sow = 1'b0;
  logic        word_ready = 1'b0;

  logic        nib_ready, word_valid, sync_err;
  logic [15:0] nibbles;
  logic [7:0]  word_cnt;
  logic        nib_ready_l, word_valid_l, sync_err_l;
  logic [15:0] nibbles_l;
  logic [7:0]  word_cnt_l;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;

  always #5 clk = ~clk;

  nib_pack #(.MSB_FIRST(1), .CNT_W(8)) dut (
    .CLK(clk), .RESET(reset), .NIB_DATA(nib_data), .NIB_VALID(nib_valid),
    .NIB_SOW(nib_sow), .NIB_READY(nib_ready), .NIBBLES(nibbles),
    .WORD_VALID(word_valid), .WORD_READY(word_ready), .SYNC_ERR(sync_err),
    .WORD_CNT(word_cnt)
  );

  nib_pack #(.MSB_FIRST(0), .CNT_W(8)) dut_lsb (
    .CLK(clk), .RESET(reset), .NIB_DATA(nib_data), .NIB_VALID(nib_valid),
    .NIB_SOW(nib_sow), .NIB_READY(nib_ready_l), .NIBBLES(nibbles_l),
    .WORD_VALID(word_valid_l), .WORD_READY(word_ready), .SYNC_ERR(sync_err_l),
    .WORD_CNT(word_cnt_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nib_valid = 1'b0;
    nib_sow = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Present one nibble and return 1 ns after the edge that accepted it.
  task automatic send_nib(input logic [3:0] d, input logic sow);
    logic ok;
    ok = 1'b0;
    nib_data  = d;
    nib_sow   = sow;
    nib_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = nib_ready;
      if (!ok) stalls++;
      tick();
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    nib_valid = 1'b0;
    nib_sow   = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_nib(w[15:12], 1'b1);
    send_nib(w[11:8],  1'b0);
    send_nib(w[7:4],   1'b0);
    send_nib(w[3:0],   1'b0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_nibbles", nibbles, 16'h0);
    check("rst_valid", word_valid, 1'b0);
    check("rst_err", sync_err, 1'b0);
    check("rst_cnt", word_cnt, 8'd0);
    check("rst_ready", nib_ready, 1'b1);

    // Basic packing and delivery count
    word_ready = 1'b1;
    send_word(16'h1234);
    check("w1234", nibbles, 16'h1234);
    check("w1234_valid", word_valid, 1'b1);
    tick();
    check("w1234_cnt", word_cnt, 8'd1);
    check("w1234_drained", word_valid, 1'b0);
    send_word(16'h1534);
    check("w1534", nibbles, 16'h1534);
    tick();
    check("w1534_cnt", word_cnt, 8'd2);

    // Back-to-back stream at full rate
    do_reset();
    stalls = 0;
    send_word(16'h1574);
    check("s1574", nibbles, 16'h1574);
    send_word(16'h8234);
    check("s8234", nibbles, 16'h8234);
    check("s_cnt_mid", word_cnt, 8'd1);
    tick();
    check("s_cnt", word_cnt, 8'd2);
    check("s_no_stall", stalls, 0);

    // Backpressure: completing nibble stalls behind a pending word
    do_reset();
    word_ready = 1'b0;
    stalls = 0;
    send_word(16'h1234);
    send_nib(4'h5, 1'b1);
    send_nib(4'h6, 1'b0);
    send_nib(4'h7, 1'b0);
    check("bp_no_early_stall", stalls, 0);
    nib_data = 4'h8; nib_valid = 1'b1;
    @(negedge clk);
    check("bp_ready_low", nib_ready, 1'b0);
    tick();
    @(negedge clk);
    check("bp_ready_low2", nib_ready, 1'b0);
    check("bp_hold", nibbles, 16'h1234);
    check("bp_hold_valid", word_valid, 1'b1);
    tick();
    word_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_high", nib_ready, 1'b1);
    tick();
    nib_valid = 1'b0;
    check("bp_second", nibbles, 16'h5678);
    check("bp_second_valid", word_valid, 1'b1);
    check("bp_cnt1", word_cnt, 8'd1);
    tick();
    check("bp_cnt2", word_cnt, 8'd2);
    check("bp_drained", word_valid, 1'b0);

    // Framing: dropped leaders, resync error, back-to-back errors
    do_reset();
    send_nib(4'h7, 1'b0);
    check("hunt_drop_err", sync_err, 1'b0);
    send_nib(4'h3, 1'b0);
    check("hunt_drop_err2", sync_err, 1'b0);
    check("hunt_no_word", word_valid, 1'b0);
    send_nib(4'h1, 1'b1);
    send_nib(4'h2, 1'b0);
    check("pre_err", sync_err, 1'b0);
    send_nib(4'h9, 1'b1);
    check("err_pulse", sync_err, 1'b1);
    send_nib(4'h8, 1'b0);
    check("err_clear", sync_err, 1'b0);
    send_nib(4'h7, 1'b0);
    send_nib(4'h6, 1'b0);
    check("resync_word", nibbles, 16'h9876);
    send_nib(4'h1, 1'b1);
    check("b2b_first_ok", sync_err, 1'b0);
    send_nib(4'h2, 1'b1);
    check("b2b_err1", sync_err, 1'b1);
    send_nib(4'h3, 1'b1);
    check("b2b_err2", sync_err, 1'b1);
    send_nib(4'h4, 1'b0);
    send_nib(4'h5, 1'b0);
    send_nib(4'h6, 1'b0);
    check("b2b_word", nibbles, 16'h3456);

    // Reset mid-word with a word pending
    do_reset();
    word_ready = 1'b0;
    send_word(16'hABCD);
    send_nib(4'h5, 1'b1);
    send_nib(4'h6, 1'b0);
    do_reset();
    check("mid_rst_nibbles", nibbles, 16'h0);
    check("mid_rst_valid", word_valid, 1'b0);
    check("mid_rst_err", sync_err, 1'b0);
    check("mid_rst_cnt", word_cnt, 8'd0);
    word_ready = 1'b1;
    send_word(16'h1234);
    check("post_rst_word", nibbles, 16'h1234);

    // LSB-first placement
    do_reset();
    send_word(16'h4321);
    check("lsb_word", nibbles_l, 16'h1234);
    check("lsb_msb_ref", nibbles, 16'h4321);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) send_word(16'h1234);
    tick();
    check("cnt_255", word_cnt, 8'd255);
    send_word(16'h1234);
    tick();
    check("cnt_wrap", word_cnt, 8'd0);
    check("cnt_wrap_lsb", word_cnt_l, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
